// File: rtl/phys_pkg.sv
// Shared types for the physics step scheduler: FSM states, pass modes and
// the frame counter width.
package phys_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT   = 2'd2,
      COMMIT = 2'd3
   } sched_state_t;

   typedef enum logic {
      LOAD = 1'b0,
      STEP = 1'b1
   } sched_mode_t;

   localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/phys_step_scheduler.sv
// Turns frame ticks into N x SPRITES update requests and load pulses into one
// initial-condition pass, ending each completed pass with a single commit pulse.
module phys_step_scheduler
   import phys_pkg::*;
#(
   parameter int SPRITES = 3,
   parameter int STEP_W  = 4,
   parameter int IDX_W   = (SPRITES > 1) ? $clog2(SPRITES) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_tick,
   input  logic                   load,
   input  logic [STEP_W-1:0]      steps_per_frame,
   output logic                   upd_valid,
   output logic [IDX_W-1:0]       upd_idx,
   output logic                   upd_init,
   input  logic                   upd_ready,
   input  logic                   upd_done,
   output logic                   commit,
   output logic                   busy,
   output logic                   overrun,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPRITES - 1);

   sched_state_t           state_q, state_d;
   sched_mode_t            mode_q, mode_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [STEP_W-1:0]      step_q, step_d;
   logic [STEP_W-1:0]      n_steps_q, n_steps_d;
   logic                   load_pend_q, load_pend_d;
   logic                   overrun_q, overrun_d;
   logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

   // Output flops, loaded from the next state so they line up with state_q.
   logic upd_valid_q, upd_valid_d;
   logic upd_init_q, upd_init_d;
   logic commit_q, commit_d;
   logic busy_q, busy_d;

   logic [STEP_W:0] step_next;
   assign step_next = {1'b0, step_q} + (STEP_W+1)'(1);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d       = state_q;
      mode_d        = mode_q;
      idx_d         = idx_q;
      step_d        = step_q;
      n_steps_d     = n_steps_q;
      load_pend_d   = load_pend_q;
      overrun_d     = overrun_q;
      frame_count_d = frame_count_q;

      // Events that arrive while a pass is in flight are remembered, never acted on directly.
      if (state_q != IDLE) begin
         if (frame_tick) overrun_d   = 1'b1;
         if (load)       load_pend_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (load || load_pend_q) begin
               state_d       = REQ;
               mode_d        = LOAD;
               idx_d         = '0;
               frame_count_d = '0;
               overrun_d     = 1'b0;
               load_pend_d   = 1'b0;
            end else if (frame_tick) begin
               n_steps_d = steps_per_frame;
               idx_d     = '0;
               step_d    = '0;
               mode_d    = STEP;
               state_d   = (steps_per_frame != '0) ? REQ : COMMIT;
            end
         end
         REQ: begin
            if (upd_ready) state_d = WAIT;
         end
         WAIT: begin
            if (upd_done) begin
               if (load_pend_q) begin
                  state_d       = REQ;
                  mode_d        = LOAD;
                  idx_d         = '0;
                  frame_count_d = '0;
                  load_pend_d   = 1'b0;
               end else if (idx_q < LAST_IDX) begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = REQ;
               end else if (mode_q == STEP && step_next < {1'b0, n_steps_q}) begin
                  step_d  = step_next[STEP_W-1:0];
                  idx_d   = '0;
                  state_d = REQ;
               end else begin
                  state_d = COMMIT;
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
            // Paused ticks also run in STEP mode, so they count as frames too.
            if (mode_q == STEP) frame_count_d = frame_count_q + FRAME_CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase

      upd_valid_d = (state_d == REQ);
      upd_init_d  = (state_d == REQ) && (mode_d == LOAD);
      commit_d    = (state_d == COMMIT);
      busy_d      = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         mode_q        <= LOAD;
         idx_q         <= '0;
         step_q        <= '0;
         n_steps_q     <= '0;
         load_pend_q   <= 1'b0;
         overrun_q     <= 1'b0;
         frame_count_q <= '0;
         upd_valid_q   <= 1'b0;
         upd_init_q    <= 1'b0;
         commit_q      <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         idx_q         <= idx_d;
         step_q        <= step_d;
         n_steps_q     <= n_steps_d;
         load_pend_q   <= load_pend_d;
         overrun_q     <= overrun_d;
         frame_count_q <= frame_count_d;
         upd_valid_q   <= upd_valid_d;
         upd_init_q    <= upd_init_d;
         commit_q      <= commit_d;
         busy_q        <= busy_d;
      end
   end

   assign upd_valid   = upd_valid_q;
   assign upd_idx     = idx_q;
   assign upd_init    = upd_init_q;
   assign commit      = commit_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_phys_step_scheduler.sv
// Scoreboard bench for phys_step_scheduler: directed passes push expected
// requests/commits; a negedge monitor pops and compares them.
module tb_phys_step_scheduler;
   import phys_pkg::*;

   localparam int SPRITES = 3;
   localparam int STEP_W  = 4;
   localparam int IDX_W   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              frame_tick = 1'b0;
   logic              load = 1'b0;
   logic [STEP_W-1:0] steps_per_frame = '0;
   logic              upd_valid;
   logic [IDX_W-1:0]  upd_idx;
   logic              upd_init;
   logic              upd_ready = 1'b1;
   logic              upd_done = 1'b0;
   logic              commit;
   logic              busy;
   logic              overrun;
   logic [15:0]       frame_count;

   phys_step_scheduler #(.SPRITES(SPRITES), .STEP_W(STEP_W)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .load(load),
      .steps_per_frame(steps_per_frame), .upd_valid(upd_valid),
      .upd_idx(upd_idx), .upd_init(upd_init), .upd_ready(upd_ready),
      .upd_done(upd_done), .commit(commit), .busy(busy),
      .overrun(overrun), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_commit;
      int idx;
      bit init;
      int fc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_req(input int idx, input bit init);
      exp_t e;
      e.is_commit = 1'b0; e.idx = idx; e.init = init; e.fc = 0;
      sb.push_back(e);
   endtask

   task automatic push_commit(input int fc);
      exp_t e;
      e.is_commit = 1'b1; e.idx = 0; e.init = 1'b0; e.fc = fc;
      sb.push_back(e);
   endtask

   // Monitor: every handshake and every commit must match the head of the scoreboard.
   initial begin
      bit   fc_pend = 1'b0;
      int   fc_exp = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (fc_pend) begin
               check("frame_count_after_commit", 32'(frame_count), 32'(fc_exp));
               fc_pend = 1'b0;
            end
            if (upd_valid && upd_ready) begin
               if (sb.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_req: idx=%0d init=%0b, scoreboard empty", upd_idx, upd_init);
               end else begin
                  e = sb.pop_front();
                  check("event_is_req", 32'(e.is_commit), 32'(0));
                  check("req_idx", 32'(upd_idx), 32'(e.idx));
                  check("req_init", 32'(upd_init), 32'(e.init));
               end
            end
            if (commit) begin
               if (sb.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_commit: scoreboard empty");
               end else begin
                  e = sb.pop_front();
                  check("event_is_commit", 32'(e.is_commit), 32'(1));
                  fc_exp  = e.fc;
                  fc_pend = 1'b1;
               end
            end
         end
      end
   end

   // Datapath model: done pulses three cycles after each accepted request.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && upd_valid && upd_ready) begin
            repeat (3) @(posedge clk);
            #1 upd_done = 1'b1;
            @(posedge clk);
            #1 upd_done = 1'b0;
         end
      end
   end

   task automatic pulse_tick(input int n);
      @(posedge clk);
      #1 steps_per_frame = STEP_W'(n);
      frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
   endtask

   task automatic pulse_load();
      @(posedge clk);
      #1 load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++; failures++;
         $display("FAIL %s: still busy after %0d cycles", name, n);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_upd_valid", 32'(upd_valid), 0);
      check("rst_upd_idx", 32'(upd_idx), 0);
      check("rst_upd_init", 32'(upd_init), 0);
      check("rst_commit", 32'(commit), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_frame_count", 32'(frame_count), 0);

      // N=2 step burst: idx 0,1,2,0,1,2 then one commit, frame_count 1.
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < SPRITES; i++) push_req(i, 1'b0);
      push_commit(1);
      pulse_tick(2);
      @(negedge clk);
      check("tick_to_valid_latency", 32'(upd_valid), 1);
      wait_idle("step_burst");
      check("step_frame_count", 32'(frame_count), 1);

      // Load pass in IDLE: three init requests, commit, frame_count cleared.
      for (int i = 0; i < SPRITES; i++) push_req(i, 1'b1);
      push_commit(0);
      pulse_load();
      wait_idle("load_pass");
      check("load_frame_count", 32'(frame_count), 0);
      check("load_overrun", 32'(overrun), 0);

      // Tick while busy is dropped and sets sticky overrun.
      for (int i = 0; i < SPRITES; i++) push_req(i, 1'b0);
      push_commit(1);
      pulse_tick(1);
      repeat (3) @(posedge clk);
      pulse_tick(1);
      wait_idle("overrun_burst");
      check("overrun_set", 32'(overrun), 1);
      check("overrun_frame_count", 32'(frame_count), 1);
      for (int i = 0; i < SPRITES; i++) push_req(i, 1'b1);
      push_commit(0);
      pulse_load();
      wait_idle("overrun_clear_load");
      check("overrun_cleared", 32'(overrun), 0);

      // Paused tick: commit the cycle after the tick, frame_count increments.
      push_commit(1);
      pulse_tick(0);
      check("paused_no_valid", 32'(upd_valid), 0);
      @(negedge clk);
      check("paused_commit_latency", 32'(commit), 1);
      wait_idle("paused_tick");
      check("paused_frame_count", 32'(frame_count), 1);

      // Load during WAIT of idx 1: abort, restart as load pass, frame_count cleared.
      push_req(0, 1'b0);
      push_req(1, 1'b0);
      for (int i = 0; i < SPRITES; i++) push_req(i, 1'b1);
      push_commit(0);
      pulse_tick(2);
      n = 0;
      while (!(upd_valid && upd_ready && upd_idx == 2'd1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; failures++;
         $display("FAIL abort_wait_idx1: handshake of idx 1 not seen");
      end
      pulse_load();
      wait_idle("abort_burst");
      check("abort_frame_count", 32'(frame_count), 0);

      // Stall in REQ: request stays stable, then async reset clears everything.
      upd_ready = 1'b0;
      pulse_tick(1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("hold_valid", 32'(upd_valid), 1);
         check("hold_idx", 32'(upd_idx), 0);
         check("hold_init", 32'(upd_init), 0);
      end
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(upd_valid), 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_commit", 32'(commit), 0);
      check("async_rst_init", 32'(upd_init), 0);
      check("async_rst_idx", 32'(upd_idx), 0);
      check("async_rst_overrun", 32'(overrun), 0);
      check("async_rst_frame_count", 32'(frame_count), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      upd_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", 32'(busy), 0);
      check("scoreboard_drained", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phys_step_scheduler.md
# phys_step_scheduler

Sequencer between the VGA frame timing and the shared physics update datapath. It turns each frame tick into a bounded burst of per-sprite update requests, N integration steps × SPRITES sprites, and turns a load request into one initial-condition pass. After each burst it pulses `commit` so the position snapshot feeding the sprite-center conversion updates exactly once per frame, and never with half-updated positions.

## Interface
- `SPRITES`, default 3: number of sprites serviced per step.
- `STEP_W`, default 4: width of the steps-per-frame input.
- `IDX_W`, default `$clog2(SPRITES)` (min 1): sprite index width.

- `clk` in 1: single clock, shared with the physics datapath.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_tick` in 1: one-cycle pulse at start of vertical blanking.
- `load` in 1: one-cycle pulse requesting initial-condition load.
- `steps_per_frame` in `STEP_W`: integration steps per frame; 0 = paused.
- `upd_valid` out 1: update request to the datapath.
- `upd_idx` out `IDX_W`: sprite index of the request.
- `upd_init` out 1: 1 = load initial conditions, 0 = integrate one step.
- `upd_ready` in 1: datapath accepts the request.
- `upd_done` in 1: one-cycle pulse when the accepted update has been written back.
- `commit` out 1: one-cycle pulse; the snapshot register latches locations.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: sticky; a frame tick was dropped.
- `frame_count` out 16: number of committed frames since the last load, wraps.

## Operation
- States: IDLE, REQ, WAIT, COMMIT.
- Internal registers:
  - `mode`: LOAD or STEP.
  - `idx`: 0..SPRITES-1.
  - `step`: 0..N-1.
  - `n_steps`: latched N.
  - `load_pend`.
- IDLE:
  - `load` or `load_pend` → REQ. Sets mode=LOAD, idx=0, clears frame_count, overrun and load_pend.
  - Otherwise, `frame_tick` → latch n_steps = `steps_per_frame`, idx=0, step=0.
    - If n_steps ≠ 0 → REQ, mode=STEP.
    - If n_steps = 0 → COMMIT.
  - `load` and `frame_tick` in the same cycle: load wins and the tick is dropped. overrun is not set.
- REQ:
  - `upd_valid`=1, `upd_idx`=idx, `upd_init`=(mode==LOAD). All three stay stable until `upd_ready`.
  - valid&ready → WAIT.
- WAIT:
  - `upd_valid`=0.
  - On `upd_done`:
    - If load_pend → REQ, mode=LOAD, idx=0, frame_count cleared. This aborts the current burst without a commit.
    - Else if idx < SPRITES-1 → idx+1, REQ.
    - Else if mode=STEP and step < n_steps-1 → step+1, idx=0, REQ.
    - Else → COMMIT.
- COMMIT:
  - `commit`=1 for one cycle.
  - frame_count+1 (mod 2^16) in STEP mode or for a paused tick.
  - frame_count stays 0 after a LOAD pass.
  - → IDLE.
- Events outside IDLE:
  - `frame_tick` while busy → dropped; overrun set to 1 (sticky).
  - `load` while busy → sets load_pend. A second load while one is pending has no further effect.
  - `upd_done` outside WAIT → ignored.
  - `upd_ready` outside REQ → ignored.
- `steps_per_frame` is sampled only at tick acceptance. Mid-burst changes take effect on the next frame.
- `rst` mid-burst: all outputs and registers return to reset values immediately. The outstanding datapath update is abandoned; the datapath is reset by the same `rst`.

## Timing
- Reset values: `upd_valid`=0, `upd_idx`=0, `upd_init`=0, `commit`=0, `busy`=0, `overrun`=0, `frame_count`=0. State is IDLE; load_pend=0.
- Tick or load sampled in cycle t → `upd_valid` high in cycle t+1. A paused tick gives `commit` in t+1.
- Handshake in cycle t → `upd_valid` low in t+1.
- `upd_done` in cycle t → next `upd_valid` in t+1, or `commit` in t+1.
- Minimum burst length, with zero-latency ready/done: 2·N·SPRITES + 1 cycles from tick to commit.
- `frame_count` reflects the increment in the cycle after `commit`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `phys_pkg`:
  - state enum `sched_state_t` {IDLE, REQ, WAIT, COMMIT}.
  - mode enum `sched_mode_t` {LOAD, STEP}.
  - `FRAME_CNT_W` = 16.
- Single module; no sub-module. The step and idx counters are small enough to stay inline.

## Test plan
- Reset, then tick with N=2, SPRITES=3, ready always high, done 3 cycles after accept → idx sequence 0,1,2,0,1,2, all with upd_init=0. Exactly one commit; frame_count=1.
- Load pulse in IDLE → three requests with upd_init=1, idx 0..2, then commit. frame_count=0, overrun=0.
- Tick while busy mid-burst → tick ignored, overrun=1. Burst still ends with one commit; next load clears overrun.
- Load during WAIT of idx 1 of a STEP burst → after that done, requests restart at idx 0 with upd_init=1. No commit for the aborted frame.
- Tick with N=0 → no upd_valid; commit one cycle later; frame_count increments.
- Hold upd_ready low 10 cycles in REQ → upd_valid, upd_idx and upd_init stable throughout. Assert rst mid-hold → all outputs 0 asynchronously.
